// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the trigger-counter scheduler.
// Holds the FSM state encoding and the N_REQ/CW default sizes.
package timer_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CW_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/timer_scheduler_if.sv
// Requester + counter bundle: req/req_delay/done/busy/owner and
// timer_en/timer_trigger/timer_pulse; slave = scheduler side.
interface timer_scheduler_if
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CW    = CW_DEF
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*CW-1:0] req_delay;
  logic [N_REQ-1:0]    done;
  logic                busy;
  logic [IW-1:0]       owner;
  logic                timer_en;
  logic [CW-1:0]       timer_trigger;
  logic                timer_pulse;

  modport slave (
    input  req, req_delay, timer_pulse,
    output done, busy, owner,
    output timer_en, timer_trigger
  );

  modport master (
    output req, req_delay, timer_pulse,
    input  done, busy, owner,
    input  timer_en, timer_trigger
  );

endinterface

// File: rtl/timer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at rr_ptr.
// In: req, rr_ptr. Out: one-hot gnt, gnt_idx, any.
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one trigger counter among N_REQ requesters round-robin.
// Ports: clk, rst (async high), bus (slave). Macro: TIMER_SCHED_CANCEL_EN.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  timer_scheduler_if.slave  bus
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = 1;

  sched_state_t   state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  owner_q;
  logic [CW-1:0]  trig_q;
  logic [N_REQ-1:0] done_q;
  logic           busy_q;
  logic           en_q;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]  gnt_idx;
  logic           any;
  logic [CW-1:0]  delay_sel;
  logic [IW-1:0]  nxt_ptr;
  logic           cancel;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    delay_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) delay_sel = delay_sel | bus.req_delay[i*CW +: CW];
  end

  assign nxt_ptr = (owner_q == IW'(N_REQ-1)) ? '0 : owner_q + 1'b1;

`ifdef TIMER_SCHED_CANCEL_EN
  assign cancel = !bus.req[owner_q];
`else
  assign cancel = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner_q <= '0;
      trig_q  <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state)
        IDLE: begin
          en_q <= 1'b0;
          if (any) begin
            owner_q <= gnt_idx;
            trig_q  <= delay_sel;
            busy_q  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (cancel) begin
            rr_ptr <= nxt_ptr;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            en_q  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (cancel) begin
            en_q   <= 1'b0;
            rr_ptr <= nxt_ptr;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (bus.timer_pulse) begin
            en_q   <= 1'b0;
            done_q <= ONE << owner_q;
            state  <= DONE;
          end
        end
        DONE: begin
          rr_ptr <= nxt_ptr;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.owner         = owner_q;
  assign bus.timer_en      = en_q;
  assign bus.timer_trigger = trig_q;

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Round-robin scheduler that shares the cipher's single 8-bit trigger counter among `N_REQ` requesters. Each requester asks for a delay. The scheduler grants the counter to one requester at a time, loads the trigger value, and runs the counter. When the counter pulses it returns a one-cycle `done` to the owner. It sits between the key/stream control logic and the existing counter instance, and drives that counter's `en` and `trigger_count` ports.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `CW`, default 8: counter/delay width; must match the counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in `N_REQ`: level request per requester; held until its `done`.
- `req_delay` in `N_REQ*CW`: requester i's delay in bits `[i*CW +: CW]`; sampled at grant only.
- `done` out `N_REQ`: one-cycle completion pulse to the owner.
- `busy` out 1: high in any state other than IDLE.
- `owner` out `$clog2(N_REQ)`: index of the current grantee; valid while `busy`.
- `timer_en` out 1: to counter `en`.
- `timer_trigger` out `CW`: to counter `trigger_count`.
- `timer_pulse` in 1: from counter `pulse`.

## Operation
- The FSM has four states: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `timer_en`=0.
  - If any `req` is set, the round-robin arbiter picks index `g`, starting its search at `rr_ptr`.
  - Latch `owner`=`g` and `trig_q`=`req_delay[g]`, then go to LOAD.
- **LOAD**
  - `timer_en`=0 for exactly one cycle, which guarantees the counter holds 0.
  - Go to RUN.
- **RUN**
  - `timer_en`=1.
  - When `timer_pulse`=1, go to DONE.
  - `timer_pulse` is ignored in every other state; the counter pulses while idle whenever trigger==0.
- **DONE**
  - `timer_en`=0 and `done[owner]`=1.
  - Set `rr_ptr`=(`owner`+1) mod `N_REQ`, then go to IDLE.
- `timer_trigger` is driven from `trig_q` at all times.
- Requesters must deassert `req` in the cycle after `done`. A `req` still high in IDLE is treated as a new request.
- `req_delay` changes after the grant have no effect on the running delay.
- Reset values:
  - state=IDLE, `rr_ptr`=0, `trig_q`=0, `owner`=0.
  - `done`=0, `busy`=0, `timer_en`=0.
- Asserting `rst` mid-operation aborts immediately:
  - No `done` is issued.
  - `timer_en` drops asynchronously.
  - A requester still holding `req` after reset is re-arbitrated from `rr_ptr`=0.

## Timing
- Edge numbering: `req` is sampled at edge E0 in IDLE.
- Per-state timing for delay D:
  - LOAD occupies [E0,E1].
  - RUN starts at E1 with count=0; count=k in RUN cycle k.
  - The pulse occurs in RUN cycle D.
  - DONE occupies [E(D+2), E(D+3)].
  - `done` is high in that single cycle.
- Total request-to-done: D+2 edges. D=0 gives one RUN cycle. D=255 gives 256 RUN cycles, with no wrap inside RUN because the pulse fires first.
- Back-to-back: DONE→IDLE→LOAD, so the next grant is sampled one cycle after `done`. The minimum gap between successive grants is D+4 cycles.
- Arbitration on simultaneous requests is strictly round-robin from `rr_ptr`. Example: with `rr_ptr`=2 and `req`=4'b1011, index 3 wins.

## Configuration
- `TIMER_SCHED_CANCEL_EN` defined:
  - If `req[owner]` drops while in LOAD or RUN, go to IDLE on the next edge.
  - `timer_en`=0, no `done` is issued, and `rr_ptr` advances to `owner`+1.
- Macro undefined:
  - `req` is not monitored after the grant.
  - The delay runs to completion and `done` is always issued.

## Structure
- `timer_sched_pkg` holds:
  - the state enum (IDLE/LOAD/RUN/DONE, 2-bit encoding);
  - the `CW` default constant;
  - the `N_REQ` default constant.
- Sub-module `rr_arbiter`:
  - Combinational.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: one-hot `gnt` and `gnt_idx`, with `any` flag.
- FSM, latches and the `done` decode live in `timer_scheduler`.
- The existing counter is instantiated outside the block, by the parent.

## Test plan
- Single request: `req`=0001 with delay 5. Expect `done[0]` high exactly 7 edges after the sampling edge, and `timer_en` high for exactly 6 cycles.
- Boundary delays:
  - Delay 0: `done` at E2.
  - Delay 255: `done` at E257.
  - No spurious `done` from the idle-state pulse at trigger=0.
- Round-robin: `req`=1111 held, each requester re-asserting after its own `done`. Expect grant order 0,1,2,3,0, and `owner` to track that order.
- Delay latching: change `req_delay[1]` from 10 to 3 one cycle after its grant. Expect the delay to remain 10.
- Reset mid-RUN: assert `rst` at RUN cycle 4 of a delay-9 request. Expect immediate `busy`=0, `timer_en`=0, no `done`, and `rr_ptr`=0 after release.
- Cancel, with `TIMER_SCHED_CANCEL_EN`: drop `req[2]` in RUN cycle 3. Expect IDLE on the next edge, no `done[2]`, and the next grant searching from index 3. Without the macro, `done[2]` still fires on schedule.
